// File: rtl/sm_regdump_pkg.sv
// Shared definitions for the register-dump block: FSM encodings, ASCII codes
// and default timing parameters.
package sm_regdump_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_NEXT    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam int DEFAULT_CLK_DIV = 434;
  localparam int DEFAULT_SETTLE  = 2;

  localparam logic [3:0] LAST_CHAR = 4'd9;   // 8 hex digits + CR + LF
  localparam logic [4:0] LAST_ADDR = 5'd31;

endpackage

// File: rtl/sm_uart_tx.sv
// 8N1 UART transmitter; a byte is accepted on valid&&ready and ready returns
// high once the full stop bit has been driven.
module sm_uart_tx
  import sm_regdump_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic [3:0]  bit_cnt;
  logic [15:0] div_cnt;
  logic [8:0]  shreg;

  assign ready = !active;

  // The start bit is driven on the accept edge; shreg holds data bits then the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      bit_cnt <= 4'd0;
      div_cnt <= 16'd0;
      shreg   <= 9'd0;
      tx      <= 1'b1;
    end else if (!active) begin
      if (valid) begin
        active  <= 1'b1;
        tx      <= 1'b0;
        shreg   <= {1'b1, data};
        bit_cnt <= 4'd0;
        div_cnt <= DIV_LAST;
      end
    end else if (div_cnt != 16'd0) begin
      div_cnt <= div_cnt - 16'd1;
    end else if (bit_cnt == 4'd9) begin
      active <= 1'b0;
    end else begin
      tx      <= shreg[0];
      shreg   <= {1'b1, shreg[8:1]};
      bit_cnt <= bit_cnt + 4'd1;
      div_cnt <= DIV_LAST;
    end
  end

endmodule

// File: rtl/sm_regdump.sv
// Walks debug registers 0..31, printing each as 8 uppercase hex chars + CR LF
// over the UART; start is only honoured while idle.
module sm_regdump
  import sm_regdump_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int SETTLE  = DEFAULT_SETTLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [31:0] shadow;
  logic [3:0]  idx;
  logic [3:0]  nib;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (ASCII_0 + {4'd0, n}) : (ASCII_A + {4'd0, n} - 8'd10);
  endfunction

  always_comb begin
    nib = 4'd0;
    case (idx[2:0])
      3'd0: nib = shadow[31:28];
      3'd1: nib = shadow[27:24];
      3'd2: nib = shadow[23:20];
      3'd3: nib = shadow[19:16];
      3'd4: nib = shadow[15:12];
      3'd5: nib = shadow[11:8];
      3'd6: nib = shadow[7:4];
      3'd7: nib = shadow[3:0];
      default: nib = 4'd0;
    endcase
    case (idx)
      4'd8:    tx_byte = ASCII_CR;
      4'd9:    tx_byte = ASCII_LF;
      default: tx_byte = hex_char(nib);
    endcase
  end

  assign tx_valid = (state == S_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      regAddr    <= 5'd0;
      settle_cnt <= 4'd0;
      shadow     <= 32'd0;
      idx        <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            regAddr    <= 5'd0;
            settle_cnt <= SETTLE_LAST;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) state <= S_CAPTURE;
          else settle_cnt <= settle_cnt - 4'd1;
        end
        S_CAPTURE: begin
          shadow <= regData;
          idx    <= 4'd0;
          state  <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (idx == LAST_CHAR) state <= S_NEXT;
            else idx <= idx + 4'd1;
          end
        end
        S_NEXT: begin
          // Hold regAddr until the LF frame has fully left the line.
          if (tx_ready) begin
            if (regAddr == LAST_ADDR) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              regAddr    <= regAddr + 5'd1;
              settle_cnt <= SETTLE_LAST;
              state      <= S_SETTLE;
            end
          end
        end
        S_FIN: begin
          regAddr <= 5'd0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sm_uart_tx #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_byte),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule
